// File: rtl/chan_readout_arb_if.sv
// Handshake/status bundle between the readout arbiter and the channel readout fabric.
interface chan_readout_arb_if #(parameter int NCH = 7);
  logic           START;
  logic [NCH-1:0] DAVACT;
  logic [NCH-1:0] KILL;
  logic [NCH-1:0] FIFORDY_B;
  logic           LAST;
  logic [NCH-1:0] OE;
  logic           BUSY;
  logic           DONE;
  logic           TMO;
  logic [NCH-1:0] DATANOEND;
  logic [NCH-1:0] DAVNODATA;

  modport master (
    output START, DAVACT, KILL, FIFORDY_B, LAST,
    input  OE, BUSY, DONE, TMO, DATANOEND, DAVNODATA
  );

  modport slave (
    input  START, DAVACT, KILL, FIFORDY_B, LAST,
    output OE, BUSY, DONE, TMO, DATANOEND, DAVNODATA
  );
endinterface

// File: rtl/chan_readout_arb.sv
// Per-event channel readout arbiter: hold-off, one-hot read enable, per-channel timeout.
// Define RR_ARB_EN for round-robin selection; default is fixed priority.
module chan_readout_arb #(
  parameter int NCH      = 7,
  parameter int NHI      = 2,
  parameter int HOLD_CYC = 448,
  parameter int TMO_W    = 12
) (
  input  logic              CLKCMS,
  input  logic              pop_rst,
  chan_readout_arb_if.slave bus
);
  localparam int SW = $clog2(NCH);
  localparam int HW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);

  typedef enum logic [2:0] {IDLE, HOLD, SELECT, READ, GAP, FINISH} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   act_q, act_d;
  logic [NCH-1:0]   oe_q, oe_d;
  logic [NCH-1:0]   dne_q, dne_d;
  logic [NCH-1:0]   dnd_q, dnd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    pick;
  logic             pick_vld;
`ifdef RR_ARB_EN
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    idx;
`endif

  // Arbitration over still-pending channels.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
`ifdef RR_ARB_EN
    idx = ptr_q;
    for (int k = 0; k < NCH; k++) begin
      idx = (idx == SW'(NCH-1)) ? '0 : idx + 1'b1;
      if (!pick_vld && act_q[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
`else
    for (int i = NCH-1; i >= NCH-NHI; i--) begin
      if (!pick_vld && act_q[i]) begin
        pick_vld = 1'b1;
        pick     = SW'(i);
      end
    end
    for (int i = 0; i < NCH-NHI; i++) begin
      if (!pick_vld && act_q[i]) begin
        pick_vld = 1'b1;
        pick     = SW'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    oe_d    = oe_q;
    dne_d   = dne_q;
    dnd_d   = dnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    sel_d   = sel_q;
`ifdef RR_ARB_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = HOLD;
          act_d   = bus.DAVACT & ~bus.KILL;
          dne_d   = '0;
          dnd_d   = '0;
          busy_d  = 1'b1;
          hcnt_d  = '0;
        end
      end
      HOLD: begin
        // Channels whose FIFO is still not ready after hold-off are flagged and dropped.
        if (hcnt_q == HW'(HOLD_CYC-1)) begin
          dnd_d   = act_q & bus.FIFORDY_B;
          act_d   = act_q & ~bus.FIFORDY_B;
          state_d = SELECT;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      SELECT: begin
        if (!pick_vld) begin
          state_d = FINISH;
        end else begin
          sel_d       = pick;
          oe_d        = '0;
          oe_d[pick]  = 1'b1;
          tcnt_d      = '0;
          state_d     = READ;
`ifdef RR_ARB_EN
          ptr_d       = pick;
`endif
        end
      end
      READ: begin
        // LAST takes precedence over a timeout landing on the same cycle.
        if (bus.LAST) begin
          act_d[sel_q] = 1'b0;
          oe_d         = '0;
          state_d      = GAP;
        end else if (tcnt_q == '1) begin
          dne_d[sel_q] = 1'b1;
          act_d[sel_q] = 1'b0;
          oe_d         = '0;
          tmo_d        = 1'b1;
          state_d      = GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      GAP:     state_d = SELECT;
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKCMS or posedge pop_rst) begin
    if (pop_rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      oe_q    <= '0;
      dne_q   <= '0;
      dnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      sel_q   <= '0;
`ifdef RR_ARB_EN
      ptr_q   <= SW'(NCH-1);
`endif
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      oe_q    <= oe_d;
      dne_q   <= dne_d;
      dnd_q   <= dnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      sel_q   <= sel_d;
`ifdef RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.OE        = oe_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.TMO       = tmo_q;
  assign bus.DATANOEND = dne_q;
  assign bus.DAVNODATA = dnd_q;
endmodule

// File: doc/chan_readout_arb.md
CHAN_READOUT_ARB -- requirements
Module: chan_readout_arb

Interface
REQ-001 Parameter NCH, 7, number of readout channels (2..16).
REQ-002 Parameter NHI, 2, count of top-index channels given descending fixed priority.
REQ-003 Parameter HOLD_CYC, 448, data hold-off cycles between event start and first selection (1..1023).
REQ-004 Parameter TMO_W, 12, per-channel timeout counter width.
REQ-005 CLKCMS  in  1  clock; all state on rising edge.
REQ-006 pop_rst  in  1  reset, asynchronous, active-high.
REQ-007 START  in  1  single-cycle event start pulse.
REQ-008 DAVACT  in  NCH  per-channel data-available for the event.
REQ-009 KILL  in  NCH  per-channel disable; killed channels are never latched.
REQ-010 FIFORDY_B  in  NCH  per-channel FIFO not-ready, active-low ready.
REQ-011 LAST  in  1  end-of-block marker from the currently enabled channel.
REQ-012 OE  out  NCH  one-hot registered read enable.
REQ-013 BUSY  out  1  event in progress.
REQ-014 DONE  out  1  single-cycle event-complete pulse.
REQ-015 TMO  out  1  single-cycle timeout pulse.
REQ-016 DATANOEND  out  NCH  sticky: channel timed out without LAST.
REQ-017 DAVNODATA  out  NCH  sticky: channel had DAV but FIFO not ready at hold-off expiry.

Function
REQ-018 States IDLE, HOLD, SELECT, READ, GAP, FINISH; all outputs registered.
REQ-019 IDLE: START -> HOLD; latch r_act <= DAVACT & ~KILL; clear DATANOEND, DAVNODATA; BUSY high on cycle after START.
REQ-020 START outside IDLE is ignored.
REQ-021 HOLD: hold-off counter runs HOLD_CYC cycles; on final count, DAVNODATA <= r_act & FIFORDY_B, those r_act bits cleared, -> SELECT.
REQ-022 SELECT: r_act == 0 -> FINISH; else choose one channel per arbitration rule, OE <= one-hot on next cycle, -> READ; timeout counter cleared.
REQ-023 Fixed priority: channels NCH-1 down to NCH-NHI in descending order, then channels 0 upward ascending.
REQ-024 READ: timeout counter increments each cycle; LAST -> clear selected r_act bit, OE <= 0, -> GAP.
REQ-025 READ: counter reaching 2^TMO_W-1 without LAST -> set DATANOEND bit, clear r_act bit, OE <= 0, TMO pulse, -> GAP.
REQ-026 LAST and timeout on same cycle: LAST wins; no DATANOEND, no TMO.
REQ-027 GAP: one idle cycle with OE all zero -> SELECT.
REQ-028 FINISH: DONE pulse 1 cycle, BUSY low on same edge, -> IDLE.
REQ-029 OE never has more than one bit set; OE bit of a killed channel is never set.
REQ-030 LAST outside READ is ignored.

Reset
REQ-031 pop_rst asserted: state IDLE, r_act, counters, OE, BUSY, DONE, TMO, DATANOEND, DAVNODATA all 0, RR pointer NCH-1; immediate mid-event abort, no DONE pulse.

Configuration
REQ-032 Macro RR_ARB_EN defined: round-robin; search starts at pointer+1 wrapping modulo NCH; pointer <= served channel on each selection; pointer persists across events.
REQ-033 RR_ARB_EN undefined: fixed priority per REQ-023; no pointer register.

Verification (NCH=7, NHI=2, HOLD_CYC=8, TMO_W=4)
REQ-034 DAVACT=7'h43, all ready, LAST 3 cycles into each READ -> OE order 0x40, 0x01, 0x02; DONE once; DATANOEND=DAVNODATA=0.
REQ-035 DAVACT=7'h05, FIFORDY_B=7'h04 at hold-off expiry -> DAVNODATA=7'h04; only OE=0x01 issued.
REQ-036 DAVACT=7'h01, no LAST -> TMO pulse after 15 READ cycles; DATANOEND=7'h01; DONE follows.
REQ-037 DAVACT=7'h7F, KILL=7'h20 -> OE never 0x20; six channels served; LAST with counter at 15 -> no TMO.
REQ-038 pop_rst in READ -> OE=0, BUSY=0 asynchronously; next START restarts cleanly.
REQ-039 RR_ARB_EN, DAVACT=7'h03 for two events -> OE order 0x01,0x02 then 0x01,0x02; DAVACT=7'h01 then 7'h03 -> second event order 0x02,0x01.
